mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
Sequences the single shared RAM port between the instruction-fetch and data-access requesters driven by the request unit. It grants one requester at a time, waits on the RAM handshake and returns the load data. It stalls the losing requester via its wait line. Data has priority, with a bounded-starvation guarantee for instruction fetch.

Parameters:
STARVE_LIMIT, 4, max consecutive data grants while an instruction request is pending before instruction is forced (0 = strict data priority, no forcing)
ADDR_W, 32, address/data word width

Ports:
CLK  in  1  clock, rising edge
nRST  in  1  reset, asynchronous, active-low
iREN  in  1  instruction read request
iaddr  in  ADDR_W  instruction address
iwait  out  1  instruction stall; low only in the completing cycle
iload  out  ADDR_W  instruction data; valid when iREN & !iwait
dREN  in  1  data read request
dWEN  in  1  data write request
daddr  in  ADDR_W  data address
dstore  in  ADDR_W  data write value
dwait  out  1  data stall; low only in the completing cycle
dload  out  ADDR_W  data read value; valid when dREN & !dwait
ramREN  out  1  RAM read enable
ramWEN  out  1  RAM write enable
ramaddr  out  ADDR_W  RAM address
ramstore  out  ADDR_W  RAM write value
ramload  in  ADDR_W  RAM read value
ramstate  in  2  FREE=0, BUSY=1, ACCESS=2, ERROR=3
err  out  1  sticky; set on any ERROR during a grant

Behaviour:
- Reset, asynchronous: state=IDLE, dstreak=0, err=0. The combinational outputs then give ramREN=ramWEN=0, ramaddr=ramstore=0, iload=dload=0. iwait and dwait equal their request inputs.
- FSM states are IDLE, IGRANT and DGRANT, registered.
- IDLE decision:
  - dreq = dREN|dWEN.
  - If iREN & (STARVE_LIMIT!=0) & (dstreak==STARVE_LIMIT), go to IGRANT.
  - Else if dreq, go to DGRANT.
  - Else if iREN, go to IGRANT.
  - Else stay in IDLE.
  - No RAM signal is driven in IDLE.
- IGRANT: ramREN=1, ramaddr=iaddr.
- DGRANT: ramaddr=daddr.
  - If dWEN: ramWEN=1, ramstore=dstore, ramREN=0. Write wins when dREN and dWEN are both high.
  - Else ramREN=1.
- Completion happens in a grant state when ramstate==ACCESS.
  - The owner's wait goes low for exactly that cycle.
  - The owner's load output equals ramload for that cycle. Both load outputs are 0 at all other times.
  - Next state is IDLE.
- Minimum latency is 2 cycles from request to completion: one IDLE cycle, then a grant cycle in which ACCESS is seen. Back-to-back requests therefore complete at most every 2 cycles.
- FREE or BUSY in a grant state: hold the state and hold the RAM outputs.
- ERROR in a grant state: set err, hold wait high and return to IDLE. The request is re-arbitrated, which gives an automatic retry. err clears only on reset.
- Request withdrawn mid-grant (owner's request input low): abort. Drop the RAM enables in that cycle, go to IDLE and do not complete. The RAM outputs follow the state, so the enables drop combinationally.
- dstreak, updated on each IDLE→grant transition:
  - DGRANT taken with iREN high: dstreak++, saturating at STARVE_LIMIT.
  - IGRANT taken: dstreak=0.
  - DGRANT taken with iREN low: dstreak=0.
  - Width is $clog2(STARVE_LIMIT+1), minimum 1.
- The non-owner's wait equals its request input throughout.

Decomposition:
- cpu_types_pkg gains:
  - ramstate_t enum (FREE, BUSY, ACCESS, ERROR)
  - arb_state_t enum (IDLE, IGRANT, DGRANT)
  - word_t, if not already present
- A single file is natural: next-state/output logic plus the dstreak counter. No sub-module is required.
- Ports are bundled in a new mem_arbiter_if with modport arb for this block and modport tb for the bench.

Test Plan:
- Reset: hold nRST=0 with iREN=1 → ramREN=0, ramWEN=0, iwait=1, err=0; release → IGRANT on the next edge.
- Lone fetch: iREN=1, iaddr=0x100, RAM returns ACCESS after 2 BUSY cycles with ramload=0xDEADBEEF → ramaddr=0x100; iwait low for exactly one cycle with iload=0xDEADBEEF at cycle 4.
- Conflict: iREN=1 and dWEN=1 together, daddr=0x200, dstore=0x12345678 → ramWEN first with ramstore=0x12345678; the instruction completes next.
- Starvation, STARVE_LIMIT=2: iREN held high, data requests continuous, RAM always ACCESS → order D, D, I, D, D, I.
- Error: ramstate=ERROR on a data read → err=1 and dwait stays 1; after retry with ACCESS the data completes and err stays 1.
- Abort and reset mid-grant:
  - dREN dropped while BUSY → ramREN=0 the same cycle and IDLE next.
  - nRST pulsed low during IGRANT → IDLE immediately, dstreak=0, err=0.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared CPU-side types: memory handshake states, arbiter FSM states and
// the machine word. Imported by the memory arbiter and its interface.
package cpu_types_pkg;

  localparam int WORD_W = 32;

  typedef logic [WORD_W-1:0] word_t;

  // Handshake status reported by the RAM model/controller.
  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  // Ownership of the shared RAM port.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    IGRANT = 2'd1,
    DGRANT = 2'd2
  } arb_state_t;

  // Width of the data-streak counter; a limit of 0 still needs one bit.
  function automatic int streak_w(input int limit);
    return (limit < 1) ? 1 : $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Signal bundle between the request unit, the arbiter and the RAM port.
interface mem_arbiter_if
  import cpu_types_pkg::*;
#(
  parameter int ADDR_W = 32
) ();

  // Instruction-fetch side
  logic              iREN;
  logic [ADDR_W-1:0] iaddr;
  logic              iwait;
  logic [ADDR_W-1:0] iload;

  // Data-access side
  logic              dREN;
  logic              dWEN;
  logic [ADDR_W-1:0] daddr;
  logic [ADDR_W-1:0] dstore;
  logic              dwait;
  logic [ADDR_W-1:0] dload;

  // Shared RAM port
  logic              ramREN;
  logic              ramWEN;
  logic [ADDR_W-1:0] ramaddr;
  logic [ADDR_W-1:0] ramstore;
  logic [ADDR_W-1:0] ramload;
  ramstate_t         ramstate;

  // Sticky error flag
  logic              err;

  modport arb (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore, err
  );

  modport tb (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore, err
  );

endinterface

// File: rtl/mem_arbiter.sv
// Shares one RAM port between instruction fetch and data access. Data wins
// by default; after STARVE_LIMIT consecutive data grants with a fetch
// pending, the fetch is forced through. RAM outputs are decoded from the
// registered state so an owner withdrawing its request drops the enables
// in the same cycle.
module mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int ADDR_W       = 32
) (
  input logic        CLK,
  input logic        nRST,
  mem_arbiter_if.arb bus
);

  localparam int                SW       = streak_w(STARVE_LIMIT);
  localparam logic [SW-1:0]     LIMIT    = SW'(STARVE_LIMIT);
  localparam logic [ADDR_W-1:0] ZERO_W   = '0;

  arb_state_t    state_q;
  logic [SW-1:0] dstreak_q;
  logic          err_q;

  logic dreq;
  logic ifetch_forced;

  assign dreq          = bus.dREN | bus.dWEN;
  assign ifetch_forced = bus.iREN && (STARVE_LIMIT != 0) && (dstreak_q == LIMIT);

  // Arbitration FSM with the starvation counter and sticky error flag.
  // NOTE: every register here uses <= so all of them sample the same
  // pre-edge values; blocking assignments would leak updates between them.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q   <= IDLE;
      dstreak_q <= '0;
      err_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (ifetch_forced) begin
            state_q   <= IGRANT;
            dstreak_q <= '0;
          end else if (dreq) begin
            state_q <= DGRANT;
            if (!bus.iREN)              dstreak_q <= '0;
            else if (dstreak_q != LIMIT) dstreak_q <= dstreak_q + 1'b1;
          end else if (bus.iREN) begin
            state_q   <= IGRANT;
            dstreak_q <= '0;
          end
        end
        IGRANT: begin
          if (!bus.iREN) begin
            state_q <= IDLE;
          end else if (bus.ramstate == ACCESS) begin
            state_q <= IDLE;
          end else if (bus.ramstate == ERROR) begin
            state_q <= IDLE;
            err_q   <= 1'b1;
          end
        end
        DGRANT: begin
          if (!dreq) begin
            state_q <= IDLE;
          end else if (bus.ramstate == ACCESS) begin
            state_q <= IDLE;
          end else if (bus.ramstate == ERROR) begin
            state_q <= IDLE;
            err_q   <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // RAM port drive and requester handshakes decoded from the current owner.
  // NOTE: every output gets a default first so no path leaves one unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    bus.ramREN   = 1'b0;
    bus.ramWEN   = 1'b0;
    bus.ramaddr  = ZERO_W;
    bus.ramstore = ZERO_W;
    bus.iwait    = bus.iREN;
    bus.dwait    = dreq;
    bus.iload    = ZERO_W;
    bus.dload    = ZERO_W;
    case (state_q)
      IGRANT: begin
        if (bus.iREN) begin
          bus.ramREN  = 1'b1;
          bus.ramaddr = bus.iaddr;
          if (bus.ramstate == ACCESS) begin
            bus.iwait = 1'b0;
            bus.iload = bus.ramload;
          end
        end
      end
      DGRANT: begin
        if (dreq) begin
          bus.ramaddr = bus.daddr;
          if (bus.dWEN) begin
            bus.ramWEN   = 1'b1;
            bus.ramstore = bus.dstore;
          end else begin
            bus.ramREN = 1'b1;
          end
          if (bus.ramstate == ACCESS) begin
            bus.dwait = 1'b0;
            bus.dload = bus.ramload;
          end
        end
      end
      default: ;
    endcase
  end

  assign bus.err = err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with STARVE_LIMIT=2. Inputs change just
// after the rising edge (or mid-cycle for same-cycle checks); outputs are
// sampled on the falling edge.
module tb_mem_arbiter;
  import cpu_types_pkg::*;

  logic CLK;
  logic nRST;
  int   errors = 0;
  int   checks = 0;

  // Owner that completes in a cycle: 0 none, 1 data, 2 instruction.
  int exp_starve [12] = '{0, 1, 0, 1, 0, 2, 0, 1, 0, 1, 0, 2};
  int exp_post   [5]  = '{1, 0, 1, 0, 2};

  mem_arbiter_if #(.ADDR_W(32)) bus ();

  mem_arbiter #(.STARVE_LIMIT(2), .ADDR_W(32)) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (bus.arb)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic sample();
    @(negedge CLK);
  endtask

  function automatic logic [31:0] owner_done();
    return {30'd0, ~bus.iwait, ~bus.dwait};
  endfunction

  initial begin
    // Reset held with a fetch pending
    nRST         = 1'b0;
    bus.iREN     = 1'b1;
    bus.iaddr    = 32'h100;
    bus.dREN     = 1'b0;
    bus.dWEN     = 1'b0;
    bus.daddr    = 32'h0;
    bus.dstore   = 32'h0;
    bus.ramload  = 32'hDEADBEEF;
    bus.ramstate = BUSY;
    sample();
    sample();
    check("rst_ramREN",  32'(bus.ramREN), 32'd0);
    check("rst_ramWEN",  32'(bus.ramWEN), 32'd0);
    check("rst_iwait",   32'(bus.iwait),  32'd1);
    check("rst_dwait",   32'(bus.dwait),  32'd0);
    check("rst_err",     32'(bus.err),    32'd0);
    check("rst_ramaddr", bus.ramaddr,     32'h0);
    check("rst_iload",   bus.iload,       32'h0);
    nRST = 1'b1;
    step();
    sample();
    check("rel_igrant_ren",  32'(bus.ramREN), 32'd1);
    check("rel_igrant_addr", bus.ramaddr,     32'h100);
    // Fetch withdrawn mid-grant: enables drop at once
    bus.iREN = 1'b0;
    #1;
    check("iabort_ramREN", 32'(bus.ramREN), 32'd0);
    step();

    // Lone fetch: IDLE, BUSY, BUSY, ACCESS
    bus.iREN = 1'b1;
    sample();
    check("fetch_c1_ramREN", 32'(bus.ramREN), 32'd0);
    check("fetch_c1_iwait",  32'(bus.iwait),  32'd1);
    step();
    sample();
    check("fetch_c2_ramREN", 32'(bus.ramREN), 32'd1);
    check("fetch_c2_addr",   bus.ramaddr,     32'h100);
    check("fetch_c2_iwait",  32'(bus.iwait),  32'd1);
    check("fetch_c2_iload",  bus.iload,       32'h0);
    step();
    sample();
    check("fetch_c3_iwait",  32'(bus.iwait),  32'd1);
    step();
    bus.ramstate = ACCESS;
    sample();
    check("fetch_c4_iwait",  32'(bus.iwait),  32'd0);
    check("fetch_c4_iload",  bus.iload,       32'hDEADBEEF);
    step();
    bus.iREN     = 1'b0;
    bus.ramstate = BUSY;
    sample();
    check("fetch_after_iload",  bus.iload,       32'h0);
    check("fetch_after_ramREN", 32'(bus.ramREN), 32'd0);

    // Conflict: data write goes first, fetch follows
    step();
    bus.iREN     = 1'b1;
    bus.iaddr    = 32'h300;
    bus.dWEN     = 1'b1;
    bus.daddr    = 32'h200;
    bus.dstore   = 32'h12345678;
    bus.ramstate = ACCESS;
    bus.ramload  = 32'hCAFEF00D;
    sample();
    check("conf_idle_ramWEN", 32'(bus.ramWEN), 32'd0);
    check("conf_idle_dwait",  32'(bus.dwait),  32'd1);
    step();
    sample();
    check("conf_d_ramWEN",   32'(bus.ramWEN), 32'd1);
    check("conf_d_ramREN",   32'(bus.ramREN), 32'd0);
    check("conf_d_addr",     bus.ramaddr,     32'h200);
    check("conf_d_store",    bus.ramstore,    32'h12345678);
    check("conf_d_dwait",    32'(bus.dwait),  32'd0);
    check("conf_d_iwait",    32'(bus.iwait),  32'd1);
    step();
    bus.dWEN = 1'b0;
    sample();
    check("conf_idle2_ramREN", 32'(bus.ramREN), 32'd0);
    step();
    sample();
    check("conf_i_ramREN", 32'(bus.ramREN), 32'd1);
    check("conf_i_addr",   bus.ramaddr,     32'h300);
    check("conf_i_iwait",  32'(bus.iwait),  32'd0);
    check("conf_i_iload",  bus.iload,       32'hCAFEF00D);
    step();

    // Starvation bound with continuous data reads and instant ACCESS
    bus.iREN  = 1'b1;
    bus.dREN  = 1'b1;
    bus.iaddr = 32'h500;
    bus.daddr = 32'h400;
    for (int k = 0; k < 12; k++) begin
      sample();
      check($sformatf("starve_%0d", k), owner_done(), 32'(exp_starve[k]));
      step();
    end
    bus.iREN = 1'b0;
    bus.dREN = 1'b0;

    // ERROR on a data read, then retry completes
    bus.dREN     = 1'b1;
    bus.daddr    = 32'h600;
    bus.ramstate = ERROR;
    sample();
    check("err_idle_err", 32'(bus.err), 32'd0);
    step();
    sample();
    check("err_g_dwait",  32'(bus.dwait),  32'd1);
    check("err_g_ramREN", 32'(bus.ramREN), 32'd1);
    check("err_g_dload",  bus.dload,       32'h0);
    step();
    sample();
    check("err_set",       32'(bus.err),    32'd1);
    check("err_idle_dwait", 32'(bus.dwait), 32'd1);
    check("err_idle_ren",  32'(bus.ramREN), 32'd0);
    bus.ramstate = ACCESS;
    bus.ramload  = 32'h0BADCAFE;
    step();
    sample();
    check("retry_dwait", 32'(bus.dwait), 32'd0);
    check("retry_dload", bus.dload,      32'h0BADCAFE);
    check("retry_err",   32'(bus.err),   32'd1);
    step();
    bus.dREN = 1'b0;
    sample();
    check("retry_after_err",   32'(bus.err), 32'd1);
    check("retry_after_dload", bus.dload,    32'h0);

    // Data read withdrawn while BUSY
    step();
    bus.dREN     = 1'b1;
    bus.daddr    = 32'h700;
    bus.ramstate = BUSY;
    step();
    sample();
    check("dabort_g_ren",   32'(bus.ramREN), 32'd1);
    check("dabort_g_addr",  bus.ramaddr,     32'h700);
    check("dabort_g_dwait", 32'(bus.dwait),  32'd1);
    bus.dREN = 1'b0;
    #1;
    check("dabort_ren_drop",  32'(bus.ramREN), 32'd0);
    check("dabort_addr_drop", bus.ramaddr,     32'h0);
    step();
    bus.dREN = 1'b1;
    sample();
    check("dabort_idle_next", 32'(bus.ramREN), 32'd0);
    step();
    sample();
    check("dabort_regrant", 32'(bus.ramREN), 32'd1);
    bus.dREN = 1'b0;
    step();

    // Reset pulsed during an instruction grant
    bus.iREN     = 1'b1;
    bus.iaddr    = 32'h800;
    bus.ramstate = BUSY;
    step();
    sample();
    check("rstg_ren",  32'(bus.ramREN), 32'd1);
    check("rstg_addr", bus.ramaddr,     32'h800);
    check("rstg_err",  32'(bus.err),    32'd1);
    nRST = 1'b0;
    #1;
    check("rstg_ren_drop", 32'(bus.ramREN), 32'd0);
    check("rstg_err_clr",  32'(bus.err),    32'd0);
    check("rstg_iwait",    32'(bus.iwait),  32'd1);
    bus.dREN     = 1'b1;
    bus.daddr    = 32'h400;
    bus.ramstate = ACCESS;
    #1;
    nRST = 1'b1;
    step();
    // Cleared streak gives two data grants before the fetch is forced
    for (int k = 0; k < 5; k++) begin
      sample();
      check($sformatf("post_rst_%0d", k), owner_done(), 32'(exp_post[k]));
      step();
    end
    bus.iREN = 1'b0;
    bus.dREN = 1'b0;
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
